// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq_if.sv
// Bus bundle for the round-robin sequenced 4:1 mux: per-requester request
// and data inputs, registered grant, select code and selected data outputs.
interface gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq_if;
  logic [3:0] REQ;
  logic       I0;
  logic       I1;
  logic       I2;
  logic       I3;
  logic [3:0] GNT;
  logic       S0;
  logic       S1;
  logic       Z;
  logic       ZV;

  modport master (
    output REQ, I0, I1, I2, I3,
    input  GNT, S0, S1, Z, ZV
  );

  modport slave (
    input  REQ, I0, I1, I2, I3,
    output GNT, S0, S1, Z, ZV
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq.sv
// Round-robin arbitrated 4:1 mux with a break-before-make GAP cycle between tenures.
// Define MUX4_RRSEQ_BURST_LIMIT_EN to cap a tenure at MAX_BURST cycles while others wait.
module gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic                                   CLK,
  input logic                                   RST,
  gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_illegal
    $error("MAX_BURST must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       z_q, z_d;
  logic       zv_q, zv_d;

  logic [3:0] req;
  logic [3:0] data;
  logic [1:0] win;
  logic       limit_hit;

  // Lowest offset from the pointer wins, so scan offsets from high to low.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick_winner = p;
    for (int n = 3; n >= 0; n--) begin
      idx = p + 2'(n);
      if (r[idx]) pick_winner = idx;
    end
  endfunction

  assign req  = bus.REQ;
  assign data = {bus.I3, bus.I2, bus.I1, bus.I0};
  assign win  = pick_winner(req, ptr_q);

`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
  localparam logic [3:0] BurstMax = 4'(MAX_BURST);
  logic [3:0] burst_q, burst_d;

  assign limit_hit = (burst_q == BurstMax) && |(req & ~gnt_q);
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    z_d     = z_q;
    zv_d    = zv_q;
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        zv_d    = 1'b0;
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
          burst_d = 4'd1;
`endif
        end
      end
      GRANT: begin
        // Leaving a tenure drops the grant but keeps select and data stable.
        if (!req[sel_q] || limit_hit) begin
          state_d = GAP;
          ptr_d   = sel_q + 2'd1;
          gnt_d   = 4'b0000;
          zv_d    = 1'b0;
        end else begin
          z_d  = data[sel_q];
          zv_d = 1'b1;
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
          if (burst_q != BurstMax) burst_d = burst_q + 4'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        zv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      z_q     <= 1'b0;
      zv_q    <= 1'b0;
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
      burst_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign bus.GNT = gnt_q;
  assign bus.S0  = sel_q[0];
  assign bus.S1  = sel_q[1];
  assign bus.Z   = z_q;
  assign bus.ZV  = zv_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq.sv
// Directed-vector bench for the round-robin 4:1 mux: per-cycle vector table
// plus hand sequences for burst rotation and burst-count saturation.
module tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq;

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq_if bus ();

  gf180mcu_fd_sc_mcu7t5v0__mux4_rrseq #(.MAX_BURST(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       z;
    logic       zv;
  } vec_t;

  vec_t vecs [30];

  task automatic check_output(input string name, input int idx,
                              input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, got, want);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after it.
  task automatic apply_stimulus(input logic rst, input logic [3:0] req, input logic [3:0] din);
    @(negedge CLK);
    RST     = rst;
    bus.REQ = req;
    {bus.I3, bus.I2, bus.I1, bus.I0} = din;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] exp_gnt;
    errors  = 0;
    checks  = 0;
    RST     = 1'b1;
    bus.REQ = 4'b0000;
    {bus.I3, bus.I2, bus.I1, bus.I0} = 4'b0000;

    //               rst   req      din      gnt      sel   z     zv
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[22] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 4'b0011, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[29] = '{1'b1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int v = 0; v < 30; v++) begin
      apply_stimulus(vecs[v].rst, vecs[v].req, vecs[v].din);
      check_output("gnt", v, bus.GNT, vecs[v].gnt);
      check_output("sel", v, {2'b00, bus.S1, bus.S0}, {2'b00, vecs[v].sel});
      check_output("z",   v, {3'b000, bus.Z},  {3'b000, vecs[v].z});
      check_output("zv",  v, {3'b000, bus.ZV}, {3'b000, vecs[v].zv});
    end

    // All four requesting continuously: rotation with one GAP between tenures.
    for (int c = 0; c < 25; c++) begin
      apply_stimulus(1'b0, 4'b1111, 4'b0000);
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
      exp_gnt = (c % 5 == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
`else
      exp_gnt = 4'b0001;
`endif
      check_output("burst_gnt", c, bus.GNT, exp_gnt);
      check_output("onehot", c, {1'b0, 3'($countones(bus.GNT) <= 1)}, 4'b0001);
    end

    // Lone requester saturates its burst count; a late rival preempts at once.
    apply_stimulus(1'b1, 4'b0000, 4'b0000);
    check_output("sat_reset", 0, bus.GNT, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b0, 4'b0001, 4'b0000);
      check_output("sat_hold", c, bus.GNT, 4'b0001);
    end
    apply_stimulus(1'b0, 4'b0011, 4'b0000);
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
    check_output("sat_exit", 0, bus.GNT, 4'b0000);
`else
    check_output("sat_exit", 0, bus.GNT, 4'b0001);
`endif
    apply_stimulus(1'b0, 4'b0011, 4'b0000);
`ifdef MUX4_RRSEQ_BURST_LIMIT_EN
    check_output("sat_next", 0, bus.GNT, 4'b0010);
`else
    check_output("sat_next", 0, bus.GNT, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
